axi_lite_gpio_arbiter: RTL

Round-robin arbiter that shares the single AXI4-Lite slave port of axi_lite_gpio_v1_0 between REQ_COUNT local requesters. Each requester issues simple one-shot read or write commands. The block grants one command at a time, drives the full AXI4-Lite master handshake on all five channels, and returns the read data and response to the granted requester. It sits between software-side or hardware-side command sources and the GPIO IP.

---
 rtl/axi_lite_gpio_arbiter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_gpio_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master port between requesters.
// Ports: s_axi_* clk/rst, req_*/rsp_* command side, m_axi_* five AXI channels.
module axi_lite_gpio_arbiter #(
  parameter int REQ_COUNT = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic                          s_axi_aclk,
  input  logic                          s_axi_aresetn,
  input  logic [REQ_COUNT-1:0]          req_valid,
  input  logic [REQ_COUNT-1:0]          req_write,
  input  logic [REQ_COUNT*ADDR_W-1:0]   req_addr,
  input  logic [REQ_COUNT*DATA_W-1:0]   req_wdata,
  input  logic [REQ_COUNT*DATA_W/8-1:0] req_wstrb,
  output logic [REQ_COUNT-1:0]          req_ready,
  output logic [REQ_COUNT-1:0]          rsp_valid,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic [1:0]                    rsp_resp,
  output logic [ADDR_W-1:0]             m_axi_awaddr,
  output logic [2:0]                    m_axi_awprot,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [DATA_W-1:0]             m_axi_wdata,
  output logic [DATA_W/8-1:0]           m_axi_wstrb,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  input  logic [1:0]                    m_axi_bresp,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,
  output logic [ADDR_W-1:0]             m_axi_araddr,
  output logic [2:0]                    m_axi_arprot,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [DATA_W-1:0]             m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready
);

  localparam int SW = DATA_W / 8;
  localparam int IW = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1;

  typedef enum logic [2:0] {
    IDLE, WRITE, WRESP, READ, RDATA, DONE
  } state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   gnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [SW-1:0]   wstrb_q;
  logic            aw_done;
  logic            w_done;

  logic            found;
  logic [IW-1:0]   sel;
  logic [IW-1:0]   sel_nxt;
  logic            aw_hs;
  logic            w_hs;

  function automatic logic [REQ_COUNT-1:0] onehot(input logic [IW-1:0] i);
    return REQ_COUNT'(1) << i;
  endfunction

  // First valid requester at or after the pointer, wrapping around.
  always_comb begin
    int j;
    found = 1'b0;
    sel   = '0;
    j     = 0;
    for (int k = 0; k < REQ_COUNT; k++) begin
      j = int'(ptr) + k;
      if (j >= REQ_COUNT) j = j - REQ_COUNT;
      if (!found && req_valid[j]) begin
        found = 1'b1;
        sel   = IW'(j);
      end
    end
  end

  assign sel_nxt = (int'(sel) + 1 >= REQ_COUNT) ? '0 : sel + 1'b1;

  assign req_ready = (state == IDLE && found) ? onehot(sel) : '0;

  assign aw_hs = m_axi_awvalid & m_axi_awready;
  assign w_hs  = m_axi_wvalid & m_axi_wready;

  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;
  assign m_axi_wdata  = wdata_q;
  assign m_axi_wstrb  = wstrb_q;
  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state         <= IDLE;
      ptr           <= '0;
      gnt           <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      rsp_valid     <= '0;
      rsp_rdata     <= '0;
      rsp_resp      <= 2'b00;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            gnt     <= sel;
            ptr     <= sel_nxt;
            addr_q  <= req_addr[sel*ADDR_W +: ADDR_W];
            wdata_q <= req_wdata[sel*DATA_W +: DATA_W];
            wstrb_q <= req_wstrb[sel*SW +: SW];
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            if (req_write[sel]) begin
              state         <= WRITE;
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
            end else begin
              state         <= READ;
              m_axi_arvalid <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (aw_hs) begin
            m_axi_awvalid <= 1'b0;
            aw_done       <= 1'b1;
          end
          if (w_hs) begin
            m_axi_wvalid <= 1'b0;
            w_done       <= 1'b1;
          end
          // Channels may finish in any order; move on once both have.
          if ((aw_done | aw_hs) && (w_done | w_hs)) begin
            state        <= WRESP;
            m_axi_bready <= 1'b1;
          end
        end
        WRESP: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            rsp_resp     <= m_axi_bresp;
            rsp_valid    <= onehot(gnt);
            state        <= DONE;
          end
        end
        READ: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= RDATA;
          end
        end
        RDATA: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            rsp_rdata    <= m_axi_rdata;
            rsp_resp     <= m_axi_rresp;
            rsp_valid    <= onehot(gnt);
            state        <= DONE;
          end
        end
        DONE: begin
          rsp_valid <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
